mux_rr_registrado: RTL

//  N-channel to 1 registered multiplexer with per-channel valid/ready handshake.

---
 rtl/mux_rr_registrado_pkg.sv | 16 +
 rtl/arbitro_rr.sv | 41 ++++
 rtl/mux_rr_registrado.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_rr_registrado_pkg.sv
// rtl/mux_rr_registrado_pkg.sv - shared constants and helpers for the registered N:1 mux
//
// Purpose : mode encodings and index arithmetic shared by the mux top level
//           and by future demux/arbiter blocks built on the same arbiter.
package mux_rr_registrado_pkg;

    // Value of the modo input selecting each arbitration scheme.
    localparam logic MODO_FIJO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

    // Channel index following idx, wrapping modulo n.
    function automatic int sig_indice(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - combinational round-robin arbiter
//
// Purpose : picks the first asserted request starting at puntero and walking
//           upwards with wrap-around modulo NUM_CANALES.
// Ports   : solicitudes  in   NUM_CANALES  request vector
//           puntero      in   SEL_BITS     highest-priority index (must be < NUM_CANALES)
//           concedido    out  1            some request was granted
//           indice       out  SEL_BITS     granted index (0 when concedido=0)
module arbitro_rr #(
    parameter  int NUM_CANALES = 4,
    localparam int SEL_BITS    = $clog2(NUM_CANALES)
) (
    input  logic [NUM_CANALES-1:0] solicitudes,
    input  logic [SEL_BITS-1:0]    puntero,
    output logic                   concedido,
    output logic [SEL_BITS-1:0]    indice
);

    always_comb begin
        int                  w_cand;
        logic [SEL_BITS-1:0] w_cand_idx;
        w_cand     = 0;
        w_cand_idx = '0;
        concedido  = 1'b0;
        indice     = '0;
        // Offset i from the pointer; puntero + i < 2*NUM_CANALES so one
        // subtraction is enough to wrap.
        for (int i = 0; i < NUM_CANALES; i++) begin
            w_cand = int'(puntero) + i;
            if (w_cand >= NUM_CANALES) begin
                w_cand = w_cand - NUM_CANALES;
            end
            w_cand_idx = SEL_BITS'(w_cand);
            if (!concedido && solicitudes[w_cand_idx]) begin
                concedido = 1'b1;
                indice    = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_registrado.sv
// rtl/mux_rr_registrado.sv - registered N:1 mux with valid/ready handshake and RR arbitration
//
// Purpose : selects one producer lane per cycle (fixed selector or round-robin),
//           holds the winning word in a single output register until downstream
//           accepts it. Drain and load may happen on the same edge.
// Ports   : clk          in   1                       rising-edge clock
//           reset        in   1                       synchronous, active-high
//           enb          in   1                       0 blocks new loads (drain still allowed)
//           modo         in   1                       MODO_FIJO / MODO_RR
//           selector     in   SEL_BITS                channel used in fixed mode
//           entrada      in   NUM_CANALES*DATA_BITS   channel k at [k*DATA_BITS +: DATA_BITS]
//           valido_in    in   NUM_CANALES             per-channel valid
//           listo_out    out  NUM_CANALES             per-channel ready, one-hot or zero
//           salida       out  DATA_BITS               registered word
//           valido_out   out  1                       salida holds a word
//           listo_in     in   1                       downstream ready
//           canal_out    out  SEL_BITS                source channel of salida
module mux_rr_registrado
    import mux_rr_registrado_pkg::*;
#(
    parameter  int DATA_BITS   = 4,
    parameter  int NUM_CANALES = 4,
    localparam int SEL_BITS    = $clog2(NUM_CANALES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enb,
    input  logic                             modo,
    input  logic [SEL_BITS-1:0]              selector,
    input  logic [NUM_CANALES*DATA_BITS-1:0] entrada,
    input  logic [NUM_CANALES-1:0]           valido_in,
    output logic [NUM_CANALES-1:0]           listo_out,
    output logic [DATA_BITS-1:0]             salida,
    output logic                             valido_out,
    input  logic                             listo_in,
    output logic [SEL_BITS-1:0]              canal_out
);

    logic [DATA_BITS-1:0] r_salida;
    logic                 r_valido;
    logic [SEL_BITS-1:0]  r_canal;
    logic [SEL_BITS-1:0]  r_puntero;

    logic                 w_cargar;
    logic                 w_sel_ok;
    logic                 w_fijo_concedido;
    logic                 w_rr_concedido;
    logic [SEL_BITS-1:0]  w_rr_indice;
    logic                 w_concedido;
    logic [SEL_BITS-1:0]  w_indice;
    logic                 w_transfer;
    logic [SEL_BITS-1:0]  w_puntero_sig;
    logic [DATA_BITS-1:0] w_canales [NUM_CANALES];

    // The output register can take a word when it is empty or being drained
    // on this same edge; this is what gives full throughput.
    assign w_cargar = enb & ~reset & (~r_valido | listo_in);

    // Fixed mode: an out-of-range selector never grants (only reachable when
    // NUM_CANALES is not a power of two).
    assign w_sel_ok         = (int'(selector) < NUM_CANALES);
    assign w_fijo_concedido = w_sel_ok && valido_in[selector];

    arbitro_rr #(
        .NUM_CANALES (NUM_CANALES)
    ) u_arbitro (
        .solicitudes (valido_in),
        .puntero     (r_puntero),
        .concedido   (w_rr_concedido),
        .indice      (w_rr_indice)
    );

    assign w_concedido = (modo == MODO_RR) ? w_rr_concedido : w_fijo_concedido;
    assign w_indice    = (modo == MODO_RR) ? w_rr_indice    : selector;

    // A grant always implies valido_in of that channel, so listo_out alone
    // marks the transfer.
    assign w_transfer = w_cargar & w_concedido;

    always_comb begin
        listo_out = '0;
        if (w_transfer) begin
            listo_out[w_indice] = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CANALES; k++) begin
            w_canales[k] = entrada[k*DATA_BITS +: DATA_BITS];
        end
    end

    assign w_puntero_sig = SEL_BITS'(sig_indice(int'(w_indice), NUM_CANALES));

    // Output register and round-robin pointer. The pointer also advances on
    // fixed-mode transfers so switching to RR later stays fair.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_salida  <= '0;
            r_valido  <= 1'b0;
            r_canal   <= '0;
            r_puntero <= '0;
        end else if (w_transfer) begin
            r_salida  <= w_canales[w_indice];
            r_valido  <= 1'b1;
            r_canal   <= w_indice;
            r_puntero <= w_puntero_sig;
        end else if (r_valido && listo_in) begin
            r_valido  <= 1'b0;
        end
    end

    assign salida     = r_salida;
    assign valido_out = r_valido;
    assign canal_out  = r_canal;

endmodule
